// File: rtl/io_timer.sv
// io_timer: memory-mapped prescaled 32-bit timer with compare match and level irq.
module io_timer #(
  parameter int          XLEN       = 32,
  parameter logic [15:0] BASE_ADDR  = 16'h0100,
  parameter int          PRESCALE_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     io_addr,
  input  logic            io_wr_req,
  input  logic [3:0]      io_be,
  input  logic [XLEN-1:0] io_wr_data,
  input  logic            io_rd_req,
  output logic [XLEN-1:0] io_rd_data,
  output logic            io_rd_ready,
  output logic            io_wr_ready,
  output logic            irq
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_n;
  logic is_wr;
  logic [2:0] off;
  logic [2:0] ctrl;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic [XLEN-1:0] count, compare;
  logic match;
  logic sel, req, tick, hit, wr_en, clr;
  logic [XLEN-1:0] regs [8];
  logic [XLEN-1:0] wr_merge;
  logic unused_addr;

  assign unused_addr = ^io_addr[1:0];
  assign sel = io_addr[15:5] == BASE_ADDR[15:5];
  assign req = sel & (io_wr_req | io_rd_req);
  assign tick = ctrl[0] && pcnt == prescale;
  assign hit = tick && count == compare;
  assign wr_en = state == ACK && is_wr && io_wr_req;
  assign clr = wr_en && off == 3'd4 && io_be[0] && io_wr_data[0];
  // Readies are masked by rst so a reset landing in ACK swallows the pulse.
  assign io_wr_ready = state == ACK && is_wr && !rst;
  assign io_rd_ready = state == ACK && !is_wr && !rst;
  assign irq = match & ctrl[2];

  always_comb begin
    state_n = (state == IDLE && req) ? ACK : IDLE;
  end

  always_comb begin
    regs = '{default: '0};
    regs[0] = XLEN'(ctrl);
    regs[1] = XLEN'(prescale);
    regs[2] = count;
    regs[3] = compare;
    regs[4] = XLEN'(match);
    wr_merge = regs[off];
    for (int i = 0; i < XLEN / 8; i++)
      wr_merge[i*8 +: 8] = io_be[i] ? io_wr_data[i*8 +: 8] : regs[off][i*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      is_wr      <= 1'b0;
      off        <= '0;
      io_rd_data <= '0;
      ctrl       <= '0;
      prescale   <= '0;
      pcnt       <= '0;
      count      <= '0;
      compare    <= '1;
      match      <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        is_wr <= io_wr_req;
        off   <= io_addr[4:2];
        if (!io_wr_req) io_rd_data <= regs[io_addr[4:2]];
      end
      pcnt  <= (!ctrl[0] || tick) ? '0 : pcnt + 1'b1;
      count <= (wr_en && off == 3'd2) ? wr_merge :
               (hit && ctrl[1])       ? '0 :
               tick                   ? count + 1'b1 : count;
      match <= hit | (match & ~clr);
      if (wr_en && off == 3'd0) ctrl <= wr_merge[2:0];
      if (wr_en && off == 3'd1) prescale <= wr_merge[PRESCALE_W-1:0];
      if (wr_en && off == 3'd3) compare <= wr_merge;
    end
  end
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed checks of io_timer register access, timer and handshake.
module tb_io_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] io_addr = '0;
  logic        io_wr_req = 1'b0;
  logic [3:0]  io_be = '0;
  logic [31:0] io_wr_data = '0;
  logic        io_rd_req = 1'b0;
  logic [31:0] io_rd_data;
  logic        io_rd_ready, io_wr_ready, irq;
  int n_chk = 0;
  int n_err = 0;

  io_timer dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_wr_req(io_wr_req), .io_be(io_be),
    .io_wr_data(io_wr_data), .io_rd_req(io_rd_req), .io_rd_data(io_rd_data),
    .io_rd_ready(io_rd_ready), .io_wr_ready(io_wr_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    io_addr = a; io_wr_data = d; io_be = be; io_wr_req = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!io_wr_ready && n < 8);
    chk("wr_lat", n, 1);
    @(posedge clk); #1;
    io_wr_req = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    int n;
    io_addr = a; io_rd_req = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!io_rd_ready && n < 8);
    chk("rd_lat", n, 1);
    chk(tag, io_rd_data, exp);
    @(posedge clk); #1;
    io_rd_req = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, wa, ra, hits;
    logic [31:0] rdv;
    do_reset();
    chk("rst_irq", irq, 0);
    chk("rst_rdy", {io_rd_ready, io_wr_ready}, 0);
    rd_chk("rst_ctrl", 16'h0100, 32'h0);
    rd_chk("rst_count", 16'h0108, 32'h0);
    rd_chk("rst_cmp", 16'h010C, 32'hFFFF_FFFF);

    wr(16'h0104, 32'd3, 4'hF);
    wr(16'h010C, 32'd2, 4'hF);
    wr(16'h0100, 32'd7, 4'hF);
    n = 0;
    while (!irq && n < 20) begin @(posedge clk); #1; n++; end
    chk("irq_lat", n, 12);
    rd_chk("reload_count", 16'h0108, 32'h0);
    wr(16'h0110, 32'd1, 4'h1);
    chk("w1c_irq", irq, 0);
    rd_chk("w1c_status", 16'h0110, 32'h0);

    do_reset();
    wr(16'h0104, 32'd0, 4'hF);
    wr(16'h010C, 32'd5, 4'hF);
    wr(16'h0100, 32'd1, 4'hF);
    wr(16'h0108, 32'hFFFF_FFFE, 4'hF);
    wait_cyc(1);
    rd_chk("wrap_ff", 16'h0108, 32'hFFFF_FFFF);
    wr(16'h0108, 32'hFFFF_FFFE, 4'hF);
    wait_cyc(2);
    rd_chk("wrap_0", 16'h0108, 32'h0);
    rd_chk("wrap_nomatch", 16'h0110, 32'h0);

    do_reset();
    wr(16'h0108, 32'hAAAA_AAAA, 4'hF);
    wr(16'h0108, 32'h1234_5678, 4'b0011);
    rd_chk("be_merge", 16'h0108, 32'hAAAA_5678);
    wr(16'h0104, 32'hFFFF_FFFF, 4'hF);
    rd_chk("prescale_w", 16'h0104, 32'h0000_FFFF);
    io_addr = 16'h010C; io_wr_data = 32'd7; io_be = 4'hF;
    io_wr_req = 1'b1; io_rd_req = 1'b1; wa = 0; ra = 0; rdv = '0;
    for (int c = 1; c <= 8 && ra == 0; c++) begin
      @(posedge clk); #1;
      if (io_wr_ready && wa == 0) wa = c;
      if (io_rd_ready && ra == 0) begin ra = c; rdv = io_rd_data; end
      if (wa != 0 && c == wa + 1) io_wr_req = 1'b0;
    end
    @(posedge clk); #1;
    io_rd_req = 1'b0; io_wr_req = 1'b0;
    chk("both_wr_at", wa, 1);
    chk("both_rd_at", ra, 3);
    chk("both_rd_data", rdv, 32'd7);

    io_addr = 16'h0200; io_rd_req = 1'b1; hits = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (io_rd_ready || io_wr_ready) hits++;
    end
    io_rd_req = 1'b0;
    chk("oow_noack", hits, 0);
    @(posedge clk); #1;
    rd_chk("rsvd_0x18", 16'h0118, 32'h0);

    io_addr = 16'h010C; io_wr_data = 32'h55; io_be = 4'hF; io_wr_req = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_rdy", io_wr_ready, 1);
    rst = 1'b1;
    #1 chk("rst_ack_rdy", io_wr_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; io_wr_req = 1'b0;
    chk("rst_ack_rdy2", io_wr_ready, 0);
    rd_chk("rst_ack_cmp", 16'h010C, 32'hFFFF_FFFF);

    wr(16'h0104, 32'd0, 4'hF);
    wr(16'h010C, 32'd101, 4'hF);
    wr(16'h0100, 32'd1, 4'hF);
    wr(16'h0108, 32'd100, 4'hF);
    wr(16'h0110, 32'd1, 4'h1);
    rd_chk("set_beats_clr", 16'h0110, 32'h1);
    chk("irq_masked", irq, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/io_timer.md
Name: io_timer

Overview:
- Memory-mapped timer peripheral on the core's IO bus; the responder end of the io_* request/ready interface driven by the data-side address mux.
- Provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and a level interrupt.
- Decodes a 32-byte window at BASE_ADDR of the 16-bit IO address space.
- Acknowledges every in-window access with a single-cycle ready pulse.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- BASE_ADDR, 16'h0100, window base; bits [4:0] must be 0.
- PRESCALE_W, 16, width of the PRESCALE register and the prescale counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- io_addr  in  16  byte address.
- io_wr_req  in  1  write request, held until io_wr_ready.
- io_be  in  4  byte enables for writes.
- io_wr_data  in  32  write data.
- io_rd_req  in  1  read request, held until io_rd_ready.
- io_rd_data  out  32  read data, valid while io_rd_ready=1.
- io_rd_ready  out  1  read acknowledge, one-cycle pulse.
- io_wr_ready  out  1  write acknowledge, one-cycle pulse.
- irq  out  1  level interrupt.

Behaviour:
- Interface is one clock domain, with reset synchronous and active-high on rst, sampled at the clk rising edge.
- Reset values:
  - CTRL=0, PRESCALE=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, prescale counter=0.
  - io_rd_data=0, io_rd_ready=0, io_wr_ready=0, irq=0; FSM in IDLE.
  - Reset mid-transaction aborts the access: no write commits and no ready pulse is issued.
- Address select: sel = (io_addr[15:5]==BASE_ADDR[15:5]). io_addr[1:0] is ignored.
  - Out-of-window requests are never acknowledged and have no side effects.
- Register map (offset io_addr[4:0]):
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0]; upper bits read 0.
  - 0x08 COUNT: read/write.
  - 0x0C COMPARE: read/write.
  - 0x10 STATUS: bit0 MATCH; write-1-to-clear.
  - 0x14-0x1C: read 0; writes are ignored but acknowledged.
- Handshake FSM:
  - IDLE: if sel and (io_wr_req or io_rd_req), go to ACK.
    - Latch kind: write has priority if both requests are high.
    - Latch offset.
    - For reads, register the addressed value into io_rd_data, i.e. the value before that edge's timer update.
  - ACK: drive io_wr_ready=1 or io_rd_ready=1 for exactly this cycle, then return to IDLE.
    - A write commits at the edge ending ACK, only if io_wr_req is still high. A dropped request still gets the ready pulse but no commit.
  - The IDLE cycle after ACK is mandatory, so a held request is acknowledged at most every 2 cycles.
  - Latency is request seen in cycle N -> ready in cycle N+1.
  - io_rd_data holds its last value outside ACK.
- Writes honour io_be per byte. STATUS clear uses io_be[0] & io_wr_data[0].
- Timer:
  - EN=0: the prescale counter is forced to 0 and COUNT holds.
  - EN=1: the prescale counter increments each cycle. When it equals PRESCALE it returns to 0 and a tick fires, so there is one tick every PRESCALE+1 cycles.
  - On tick:
    - If COUNT==COMPARE: MATCH<=1, and COUNT<=0 when AUTO_RELOAD else COUNT+1.
    - Otherwise COUNT<=COUNT+1.
    - COUNT wraps from 32'hFFFF_FFFF to 0 modulo 2^32 with no flag.
- Simultaneous events:
  - CPU write to COUNT in the same cycle as a tick: the write wins and the tick increment is lost.
  - CPU W1C of MATCH in the same cycle as a new match: the set wins and MATCH stays 1.
  - Writing PRESCALE or clearing EN does not reset COUNT.
- irq = MATCH & IRQ_EN, from registered state with no combinational path from inputs.

Test Plan:
- Reset, then read offsets 0x00/0x08/0x0C -> io_rd_ready 1 cycle after io_rd_req. Data is 0, 0, 32'hFFFF_FFFF respectively.
- Write PRESCALE=3, COMPARE=2, CTRL=3'b111 -> COUNT steps every 4 cycles, 0->1->2. At the third tick COUNT=0, MATCH=1 and irq=1. Write STATUS=1 -> irq=0 next cycle.
- AUTO_RELOAD=0, COUNT written 32'hFFFF_FFFE, COMPARE=5, PRESCALE=0, EN=1 -> COUNT reads FFFF_FFFF then 0, MATCH stays 0.
- Write COUNT=32'h1234_5678 with io_be=4'b0011 over old value 32'hAAAA_AAAA -> readback 32'hAAAA_5678. Both requests high at once -> io_wr_ready first, io_rd_ready 2 cycles later.
- Read at io_addr=16'h0200 (out of window) for 10 cycles -> no ready. Read at 16'h0118 -> ready with data 0.
- Assert rst during ACK of a write to COMPARE -> no ready, COMPARE=32'hFFFF_FFFF. A match coinciding with a STATUS W1C write leaves MATCH=1.
